// File: rtl/ibex_irq_arbiter.sv
// Purpose : collect irq sources, latch edge-type lines, mask with CSR enables, pick one winner by fixed priority.
// Latency : 1 cycle from an eligible source (or a rising edge on an edge-type line) in IDLE to irq_req_o=1.
// Backpr. : request held until irq_ack_i; after an ack, BLANK holds off for HOLD_CYCLES cycles before re-arbitrating.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   irq_software_i/timer_i/external_i   level machine interrupts
//   irq_fast_i[NUM_FAST]         fast lines (edge-latched when FAST_EDGE=1, level otherwise)
//   irq_nm_i                     non-maskable irq, rising-edge latched
//   csr_mstatus_mie_i, csr_mie_i global and per-source enables ([0]=sw,[1]=timer,[2]=ext,[3+k]=fast k)
//   debug_mode_i                 blocks all new requests, NMI included
//   irq_req_o/irq_nm_o/irq_cause_o  registered request, NMI flag and cause to the controller
//   irq_ack_i                    controller took the current request
//   fast_pending_o               fast pending bits before masking (mfip view)
//   busy_o                       FSM is not IDLE
module ibex_irq_arbiter #(
    parameter bit          FAST_EDGE   = 1'b1,
    parameter int unsigned NUM_FAST    = 15,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_software_i,
    input  logic                  irq_timer_i,
    input  logic                  irq_external_i,
    input  logic [NUM_FAST-1:0]   irq_fast_i,
    input  logic                  irq_nm_i,
    input  logic                  csr_mstatus_mie_i,
    input  logic [3+NUM_FAST-1:0] csr_mie_i,
    input  logic                  debug_mode_i,
    output logic                  irq_req_o,
    output logic                  irq_nm_o,
    output logic [5:0]            irq_cause_o,
    input  logic                  irq_ack_i,
    output logic [NUM_FAST-1:0]   fast_pending_o,
    output logic                  busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam logic [5:0] CAUSE_NMI   = 6'h1F;
    localparam logic [5:0] CAUSE_EXT   = 6'h0B;
    localparam logic [5:0] CAUSE_SW    = 6'h03;
    localparam logic [5:0] CAUSE_TIMER = 6'h07;

    // BLANK counts down from HOLD_CYCLES-1 to 0, so it lasts exactly HOLD_CYCLES cycles.
    localparam logic [2:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 3'(HOLD_CYCLES - 1) : 3'd0;

    logic [1:0]          state_q, state_d;
    logic [2:0]          hold_cnt_q, hold_cnt_d;
    logic                nm_prev_q;
    logic [NUM_FAST-1:0] fast_prev_q;
    logic                nmi_q;
    logic [NUM_FAST-1:0] fast_q;
    logic                req_q, req_d;
    logic                nm_q, nm_d;
    logic [5:0]          cause_q, cause_d;

    logic                nm_rise;
    logic [NUM_FAST-1:0] fast_rise;
    logic                nmi_pend;
    logic [NUM_FAST-1:0] fast_pend;
    logic                glob_en;
    logic [NUM_FAST-1:0] fast_elig;
    logic                ext_elig, sw_elig, timer_elig, nmi_elig;
    logic                win_vld;
    logic [5:0]          win_cause;
    logic                held_is_fast;
    logic                held_elig;
    logic                ack_take;
    logic                nmi_clr;
    logic [NUM_FAST-1:0] fast_clr;

    // ------------------------------------------------------------------
    // Edge detection and pending view
    // ------------------------------------------------------------------
    assign nm_rise   = irq_nm_i & ~nm_prev_q;
    assign fast_rise = irq_fast_i & ~fast_prev_q;

    // A rising edge counts as pending in the cycle it is seen, so an edge
    // in IDLE is requested on the very edge that also latches it.
    assign nmi_pend = nmi_q | nm_rise;

    always_comb begin
        if (FAST_EDGE) begin
            fast_pend      = fast_q | fast_rise;
            fast_pending_o = fast_q;
        end else begin
            fast_pend      = irq_fast_i;
            fast_pending_o = irq_fast_i;
        end
    end

    // ------------------------------------------------------------------
    // Eligibility
    // ------------------------------------------------------------------
    assign glob_en    = csr_mstatus_mie_i & ~debug_mode_i;
    assign fast_elig  = fast_pend & csr_mie_i[3 +: NUM_FAST] & {NUM_FAST{glob_en}};
    assign ext_elig   = irq_external_i & csr_mie_i[2] & glob_en;
    assign sw_elig    = irq_software_i & csr_mie_i[0] & glob_en;
    assign timer_elig = irq_timer_i    & csr_mie_i[1] & glob_en;
    assign nmi_elig   = nmi_pend & ~debug_mode_i;

    // ------------------------------------------------------------------
    // Fixed-priority winner: NMI, fast[N-1..0], ext, sw, timer
    // ------------------------------------------------------------------
    always_comb begin
        win_vld   = 1'b0;
        win_cause = 6'h00;
        if (nmi_elig) begin
            win_vld   = 1'b1;
            win_cause = CAUSE_NMI;
        end else begin
            for (int k = NUM_FAST - 1; k >= 0; k--) begin
                if (!win_vld && fast_elig[k]) begin
                    win_vld   = 1'b1;
                    win_cause = {2'b11, 4'(k)};
                end
            end
            if (!win_vld) begin
                if (ext_elig) begin
                    win_vld   = 1'b1;
                    win_cause = CAUSE_EXT;
                end else if (sw_elig) begin
                    win_vld   = 1'b1;
                    win_cause = CAUSE_SW;
                end else if (timer_elig) begin
                    win_vld   = 1'b1;
                    win_cause = CAUSE_TIMER;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Is the source held in REQ still eligible? The cause register doubles
    // as the winner id: fast causes are the only ones with bits [5:4]=11.
    // ------------------------------------------------------------------
    assign held_is_fast = (cause_q[5:4] == 2'b11);

    always_comb begin
        held_elig = 1'b0;
        if (nm_q) begin
            held_elig = nmi_elig;
        end else if (held_is_fast) begin
            for (int k = 0; k < NUM_FAST; k++) begin
                if (cause_q[3:0] == 4'(k)) begin
                    held_elig = fast_elig[k];
                end
            end
        end else begin
            case (cause_q)
                CAUSE_EXT:   held_elig = ext_elig;
                CAUSE_SW:    held_elig = sw_elig;
                CAUSE_TIMER: held_elig = timer_elig;
                default:     held_elig = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Latch clears on ack of the held winner
    // ------------------------------------------------------------------
    assign ack_take = (state_q == ST_REQ) & irq_ack_i;
    assign nmi_clr  = ack_take & nm_q;

    always_comb begin
        fast_clr = '0;
        for (int k = 0; k < NUM_FAST; k++) begin
            fast_clr[k] = ack_take & held_is_fast & (cause_q[3:0] == 4'(k));
        end
    end

    // Set has priority over clear so an edge arriving with the ack is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nm_prev_q   <= 1'b0;
            fast_prev_q <= '0;
            nmi_q       <= 1'b0;
            fast_q      <= '0;
        end else begin
            nm_prev_q   <= irq_nm_i;
            fast_prev_q <= irq_fast_i;
            nmi_q       <= nm_rise | (nmi_q & ~nmi_clr);
            if (FAST_EDGE) begin
                fast_q <= fast_rise | (fast_q & ~fast_clr);
            end else begin
                fast_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        req_d      = req_q;
        nm_d       = nm_q;
        cause_d    = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    cause_d = win_cause;
                    nm_d    = nmi_elig;
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    req_d   = 1'b0;
                    nm_d    = 1'b0;
                    cause_d = 6'h00;
                    if (HOLD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_BLANK;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end else if (!nm_q && nmi_elig) begin
                    // Only an NMI may displace a held request.
                    cause_d = CAUSE_NMI;
                    nm_d    = 1'b1;
                end else if (!held_elig) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    nm_d    = 1'b0;
                    cause_d = 6'h00;
                end
            end
            ST_BLANK: begin
                if (hold_cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                nm_d    = 1'b0;
                cause_d = 6'h00;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 3'd0;
            req_q      <= 1'b0;
            nm_q       <= 1'b0;
            cause_q    <= 6'h00;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            req_q      <= req_d;
            nm_q       <= nm_d;
            cause_q    <= cause_d;
        end
    end

    assign irq_req_o   = req_q;
    assign irq_nm_o    = nm_q;
    assign irq_cause_o = cause_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Purpose : directed self-checking bench for ibex_irq_arbiter (FAST_EDGE=1, NUM_FAST=15, HOLD_CYCLES=1).
// Latency : inputs driven 1 time unit after a rising edge, outputs checked 1 time unit after the next.
// Backpr. : acks are driven as single-cycle pulses in the cycle after a request is seen.
module tb_ibex_irq_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        irq_software_i, irq_timer_i, irq_external_i;
    logic [14:0] irq_fast_i;
    logic        irq_nm_i;
    logic        csr_mstatus_mie_i;
    logic [17:0] csr_mie_i;
    logic        debug_mode_i;
    logic        irq_req_o, irq_nm_o;
    logic [5:0]  irq_cause_o;
    logic        irq_ack_i;
    logic [14:0] fast_pending_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    ibex_irq_arbiter #(
        .FAST_EDGE   (1'b1),
        .NUM_FAST    (15),
        .HOLD_CYCLES (1)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .irq_software_i    (irq_software_i),
        .irq_timer_i       (irq_timer_i),
        .irq_external_i    (irq_external_i),
        .irq_fast_i        (irq_fast_i),
        .irq_nm_i          (irq_nm_i),
        .csr_mstatus_mie_i (csr_mstatus_mie_i),
        .csr_mie_i         (csr_mie_i),
        .debug_mode_i      (debug_mode_i),
        .irq_req_o         (irq_req_o),
        .irq_nm_o          (irq_nm_o),
        .irq_cause_o       (irq_cause_o),
        .irq_ack_i         (irq_ack_i),
        .fast_pending_o    (fast_pending_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic nm, input logic [5:0] cause);
        chk({tag, ".req"},   {31'd0, irq_req_o},   {31'd0, req});
        chk({tag, ".nm"},    {31'd0, irq_nm_o},    {31'd0, nm});
        chk({tag, ".cause"}, {26'd0, irq_cause_o}, {26'd0, cause});
    endtask

    initial begin
        rst_i = 1'b1;
        irq_software_i = 1'b0; irq_timer_i = 1'b0; irq_external_i = 1'b0;
        irq_fast_i = '0; irq_nm_i = 1'b0;
        csr_mstatus_mie_i = 1'b0; csr_mie_i = '0; debug_mode_i = 1'b0;
        irq_ack_i = 1'b0;

        // Reset state
        tick(); tick();
        chk_out("reset", 1'b0, 1'b0, 6'h00);
        chk("reset.busy", {31'd0, busy_o}, 32'd0);
        chk("reset.fpend", {17'd0, fast_pending_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        chk("idle.busy", {31'd0, busy_o}, 32'd0);

        // Single fast[5] edge pulse
        csr_mstatus_mie_i = 1'b1;
        csr_mie_i = 18'h00100;
        irq_fast_i = 15'h0020;
        tick();
        chk_out("f5.req", 1'b1, 1'b0, 6'h35);
        chk("f5.fpend", {17'd0, fast_pending_o}, 32'h20);
        chk("f5.busy", {31'd0, busy_o}, 32'd1);
        irq_fast_i = '0;
        tick();
        chk_out("f5.hold", 1'b1, 1'b0, 6'h35);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_out("f5.blank", 1'b0, 1'b0, 6'h00);
        chk("f5.fpend_clr", {17'd0, fast_pending_o}, 32'd0);
        chk("f5.blank_busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("f5.idle_busy", {31'd0, busy_o}, 32'd0);
        chk_out("f5.idle", 1'b0, 1'b0, 6'h00);

        // Ack while idle is ignored
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk("ack_idle.busy", {31'd0, busy_o}, 32'd0);
        chk("ack_idle.req", {31'd0, irq_req_o}, 32'd0);

        // ext, timer and fast[2] together: fast[2], then ext, then timer
        csr_mie_i = 18'h00026;
        irq_external_i = 1'b1;
        irq_timer_i = 1'b1;
        irq_fast_i = 15'h0004;
        tick();
        chk_out("prio.f2", 1'b1, 1'b0, 6'h32);
        irq_fast_i = '0;
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_out("prio.blank1", 1'b0, 1'b0, 6'h00);
        chk("prio.fpend", {17'd0, fast_pending_o}, 32'd0);
        tick();
        chk("prio.idle1", {31'd0, irq_req_o}, 32'd0);
        tick();
        chk_out("prio.ext", 1'b1, 1'b0, 6'h0B);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        irq_external_i = 1'b0;
        chk("prio.blank2", {31'd0, irq_req_o}, 32'd0);
        tick();
        tick();
        chk_out("prio.timer", 1'b1, 1'b0, 6'h07);

        // Held timer drops before ack: back to IDLE with no request
        irq_timer_i = 1'b0;
        tick();
        chk_out("drop.out", 1'b0, 1'b0, 6'h00);
        chk("drop.busy", {31'd0, busy_o}, 32'd0);
        tick();
        chk("drop.stay", {31'd0, irq_req_o}, 32'd0);

        // NMI displaces a held ext request, ignoring mstatus.mie
        csr_mie_i = 18'h00004;
        irq_external_i = 1'b1;
        tick();
        chk_out("nmi.ext", 1'b1, 1'b0, 6'h0B);
        csr_mstatus_mie_i = 1'b0;
        irq_nm_i = 1'b1;
        tick();
        irq_nm_i = 1'b0;
        chk_out("nmi.pre", 1'b1, 1'b1, 6'h1F);
        tick();
        chk_out("nmi.hold", 1'b1, 1'b1, 6'h1F);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        csr_mstatus_mie_i = 1'b1;
        chk_out("nmi.blank", 1'b0, 1'b0, 6'h00);
        tick();
        tick();
        chk_out("nmi.ext_again", 1'b1, 1'b0, 6'h0B);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        irq_external_i = 1'b0;
        tick();
        tick();
        chk("nmi.cleared", {31'd0, irq_req_o}, 32'd0);

        // NMI blocked in debug mode, requested once debug exits
        debug_mode_i = 1'b1;
        irq_nm_i = 1'b1;
        tick();
        irq_nm_i = 1'b0;
        chk("dbg.req0", {31'd0, irq_req_o}, 32'd0);
        tick();
        chk("dbg.req1", {31'd0, irq_req_o}, 32'd0);
        debug_mode_i = 1'b0;
        tick();
        chk_out("dbg.exit", 1'b1, 1'b1, 6'h1F);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        tick();
        tick();
        chk("dbg.cleared", {31'd0, irq_req_o}, 32'd0);

        // Asynchronous reset mid-REQ; masked fast[7] latch is lost
        csr_mie_i = 18'h00002;
        irq_timer_i = 1'b1;
        irq_fast_i = 15'h0080;
        tick();
        irq_fast_i = '0;
        chk_out("arst.req", 1'b1, 1'b0, 6'h07);
        chk("arst.fpend", {17'd0, fast_pending_o}, 32'h80);
        #2;
        rst_i = 1'b1;
        #1;
        chk_out("arst.now", 1'b0, 1'b0, 6'h00);
        chk("arst.busy", {31'd0, busy_o}, 32'd0);
        chk("arst.fpend_lost", {17'd0, fast_pending_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk_out("arst.rereq", 1'b1, 1'b0, 6'h07);
        chk("arst.fpend_after", {17'd0, fast_pending_o}, 32'd0);
        irq_timer_i = 1'b0;
        tick();
        chk("arst.idle", {31'd0, irq_req_o}, 32'd0);

        // New fast[0] edge in the same cycle fast[0] is acked: set wins
        csr_mie_i = 18'h00008;
        irq_fast_i = 15'h0001;
        tick();
        irq_fast_i = '0;
        chk_out("f0.req", 1'b1, 1'b0, 6'h30);
        tick();
        irq_fast_i = 15'h0001;
        irq_ack_i = 1'b1;
        tick();
        irq_fast_i = '0;
        irq_ack_i = 1'b0;
        chk("f0.fpend_kept", {17'd0, fast_pending_o}, 32'h1);
        chk("f0.blank", {31'd0, irq_req_o}, 32'd0);
        tick();
        tick();
        chk_out("f0.rereq", 1'b1, 1'b0, 6'h30);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk("f0.fpend_clr", {17'd0, fast_pending_o}, 32'd0);
        tick();
        tick();
        chk("f0.done", {31'd0, irq_req_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_irq_arbiter.md
Name: ibex_irq_arbiter

Overview:
- Collects the core's interrupt sources, latches edge-type sources, masks them with CSR enables and picks one winner by fixed priority.
- Presents a stable request and cause to the core controller, then runs a request/acknowledge handshake.
- On acknowledge it clears the latched pending bit of the source that was taken.
- Sits between the top-level irq pins and the controller's irq_pending/irq_nm/mfip inputs.

Parameters:
- FAST_EDGE, 1, 1: fast irq lines are rising-edge latched; 0: fast irq lines are level-sensitive.
- NUM_FAST, 15, number of fast interrupt lines (1..15).
- HOLD_CYCLES, 1, idle cycles in BLANK after an ack before the next request (0..7).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- irq_software_i  in  1  machine software irq, level.
- irq_timer_i  in  1  machine timer irq, level.
- irq_external_i  in  1  machine external irq, level.
- irq_fast_i  in  NUM_FAST  fast irq lines.
- irq_nm_i  in  1  non-maskable irq, always rising-edge latched.
- csr_mstatus_mie_i  in  1  global machine interrupt enable.
- csr_mie_i  in  3+NUM_FAST  per-source enables: [0]=sw, [1]=timer, [2]=ext, [3+k]=fast k.
- debug_mode_i  in  1  core in debug mode; blocks new requests.
- irq_req_o  out  1  request to controller; held until ack.
- irq_nm_o  out  1  current request is the NMI.
- irq_cause_o  out  6  exception cause of the current request.
- irq_ack_i  in  1  controller took the irq (pulse in its IRQ_TAKEN cycle).
- fast_pending_o  out  NUM_FAST  latched, unmasked fast pending bits (mfip view).
- busy_o  out  1  FSM not IDLE.

Behaviour:
Reset (rst_i high, asynchronous):
- FSM goes to IDLE.
- All pending latches and edge-detect history registers are cleared to 0.
- irq_req_o=0, irq_nm_o=0, irq_cause_o=0, busy_o=0, fast_pending_o=0.

Latching:
- NMI latch: sets on a 0→1 transition of irq_nm_i versus its sampled previous value. Clears only on an ack of an NMI request.
- Fast latch, edge mode (FAST_EDGE=1): each line sets on its rising edge. It clears on an ack where that line was the winner.
- Fast, level mode (FAST_EDGE=0): the pending bit equals the input line.
- Set and clear of the same bit in one cycle: set wins (a new edge is not lost).
- sw/timer/ext: always level, never latched.

Eligibility and priority:
- A maskable source is eligible when its pending bit is set, its enable bit is set, csr_mstatus_mie_i=1 and debug_mode_i=0.
- The NMI is eligible when its latch is set and debug_mode_i=0; it ignores mie and mstatus.
- Priority, highest first: NMI, fast[NUM_FAST-1] down to fast[0], external, software, timer.

Cause encoding:
- NMI = 6'h1F.
- fast k = {2'b11, k[3:0]}.
- external = 6'h0B, software = 6'h03, timer = 6'h07.

FSM (states IDLE, REQ, BLANK):
- IDLE → REQ when any source is eligible. In the same edge, register the winner's id, cause and nm flag.
- REQ:
  - irq_req_o=1; irq_cause_o and irq_nm_o are held constant from the registered winner, even if a higher-priority source arrives meanwhile.
  - Exception: if the held winner is maskable and a new NMI becomes eligible, re-arbitrate to the NMI on the next edge.
  - If the held source stops being eligible before ack (level dropped, enable cleared, debug entered), return to IDLE with no clear.
  - If irq_ack_i=1, clear the winner's latch, then go to BLANK (or IDLE if HOLD_CYCLES=0).
- BLANK: irq_req_o=0. Count HOLD_CYCLES cycles, then go to IDLE. This gives level sources time to deassert after the handler's CSR write.
- irq_ack_i while in IDLE or BLANK is ignored, with no state change.
- Latency: from an eligible source in IDLE to irq_req_o=1 is 1 cycle.
- irq_req_o, irq_nm_o and irq_cause_o are all registered outputs.
- irq_cause_o is 0 whenever irq_req_o=0.

Test Plan:
- Reset then FAST_EDGE=1, mstatus_mie=1, mie[3+5]=1, pulse irq_fast_i[5] for one cycle → next cycle irq_req_o=1, cause=6'h35, fast_pending_o[5]=1. Ack → bit clears; irq_req_o=0 for HOLD_CYCLES cycles.
- Same cycle: ext, timer and fast[2] all eligible → cause=6'h32. After ack and blank, cause=6'h0B. After that ack, cause=6'h07.
- In REQ holding ext (6'h0B), pulse irq_nm_i with mstatus_mie=0 → one cycle later cause=6'h1F, irq_nm_o=1. Ack clears the NMI latch; ext is re-requested after blank.
- In REQ holding timer, drop irq_timer_i → next cycle irq_req_o=0, FSM IDLE, no latch cleared. With debug_mode_i=1, an asserted NMI → irq_req_o stays 0.
- Assert rst_i asynchronously mid-REQ, between clock edges → outputs 0 immediately. Pending edge latches are lost; a level source still high is re-requested 1 cycle after rst_i falls.
- Fast[0] edge arrives in the same cycle fast[0] is acked → fast_pending_o[0] stays 1 and a new request follows after blank.
